core_run_sequencer: RTL and testbench

- Host-side initiator for the processor core's start/ack handshake: drives core reset and `start`, waits for `ack`, and measures run length.
- Sequences up to 16 back-to-back program runs. Each run is selected by `prog_sel`. The core is re-reset between runs because its `ack` is sticky until reset.
- Sits between the bench/host logic and the core top level. One instance per core.

---
 rtl/core_run_sequencer.sv | 170 +++++++++++++++++
 tb/tb_core_run_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/core_run_sequencer.sv
// Host-side sequencer for the core start/ack handshake: resets the core, pulses
// start, waits for ack and reports each run's latency across a batch of runs.
module core_run_sequencer #(
  parameter int RST_CYCLES     = 2,
  parameter int START_CYCLES   = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CW             = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run_req,
  input  logic [3:0]    num_runs,
  input  logic          ack,
  output logic          core_reset,
  output logic          start,
  output logic [3:0]    prog_sel,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic          run_valid,
  output logic [CW-1:0] run_cycles,
  output logic [3:0]    run_id
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_STRT,
    S_WAIT,
    S_REC,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] RST_LIM   = CW'(RST_CYCLES);
  localparam logic [CW-1:0] START_LIM = CW'(START_CYCLES);
  localparam logic [CW-1:0] TO_LIM    = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] ONE       = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    num_q, num_d;
  logic [3:0]    prog_sel_q, prog_sel_d;
  logic [3:0]    run_id_q, run_id_d;
  logic [CW-1:0] run_cycles_q, run_cycles_d;
  logic          timeout_q, timeout_d;
  logic          core_reset_q, core_reset_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          run_valid_q, run_valid_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    num_d        = num_q;
    prog_sel_d   = prog_sel_q;
    run_id_d     = run_id_q;
    run_cycles_d = run_cycles_q;
    timeout_d    = timeout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (run_req) begin
          num_d      = num_runs;
          prog_sel_d = 4'd0;
          timeout_d  = 1'b0;
          cnt_d      = ONE;
          state_d    = S_CRST;
        end
      end
      S_CRST: begin
        if (cnt_q == RST_LIM) begin
          cnt_d   = ONE;
          state_d = S_STRT;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_STRT: begin
        if (cnt_q == START_LIM) begin
          cnt_d   = ONE;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_WAIT: begin
        // ack wins over a timeout landing on the same cycle
        if (ack) begin
          run_cycles_d = cnt_q;
          run_id_d     = prog_sel_q;
          cnt_d        = '0;
          state_d      = S_REC;
        end else if (cnt_q >= TO_LIM) begin
          run_cycles_d = TO_LIM;
          run_id_d     = prog_sel_q;
          timeout_d    = 1'b1;
          cnt_d        = '0;
          state_d      = S_REC;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_REC: begin
        if (prog_sel_q == num_q) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          prog_sel_d = prog_sel_q + 4'd1;
          cnt_d      = ONE;
          state_d    = S_CRST;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the registered copies line up with state_q
    core_reset_d = (state_d == S_IDLE) || (state_d == S_CRST) ||
                   (state_d == S_REC)  || (state_d == S_DONE);
    start_d      = (state_d == S_STRT);
    busy_d       = (state_d == S_CRST) || (state_d == S_STRT) ||
                   (state_d == S_WAIT) || (state_d == S_REC);
    done_d       = (state_d == S_DONE);
    run_valid_d  = (state_d == S_REC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      num_q        <= 4'd0;
      prog_sel_q   <= 4'd0;
      run_id_q     <= 4'd0;
      run_cycles_q <= '0;
      timeout_q    <= 1'b0;
      core_reset_q <= 1'b1;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      run_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      num_q        <= num_d;
      prog_sel_q   <= prog_sel_d;
      run_id_q     <= run_id_d;
      run_cycles_q <= run_cycles_d;
      timeout_q    <= timeout_d;
      core_reset_q <= core_reset_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      run_valid_q  <= run_valid_d;
    end
  end

  assign core_reset = core_reset_q;
  assign start      = start_q;
  assign prog_sel   = prog_sel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign run_valid  = run_valid_q;
  assign run_cycles = run_cycles_q;
  assign run_id     = run_id_q;

endmodule

// File: tb/tb_core_run_sequencer.sv
// Directed bench for core_run_sequencer: single run, batch, timeout, dropped
// run_req, stuck ack and mid-run reset, each against hand-computed values.
module tb_core_run_sequencer;

  localparam int RST  = 2;
  localparam int STRC = 3;
  localparam int TO   = 20;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          run_req;
  logic [3:0]    num_runs;
  logic          ack;
  logic          core_reset;
  logic          start;
  logic [3:0]    prog_sel;
  logic          busy;
  logic          done;
  logic          timeout;
  logic          run_valid;
  logic [CW-1:0] run_cycles;
  logic [3:0]    run_id;

  int nvec = 0;
  int nmis = 0;

  core_run_sequencer #(
    .RST_CYCLES    (RST),
    .START_CYCLES  (STRC),
    .TIMEOUT_CYCLES(TO),
    .CW            (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run_req   (run_req),
    .num_runs  (num_runs),
    .ack       (ack),
    .core_reset(core_reset),
    .start     (start),
    .prog_sel  (prog_sel),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .run_valid (run_valid),
    .run_cycles(run_cycles),
    .run_id    (run_id)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input int obs, input int exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_req(input logic [3:0] n);
    num_runs = n;
    run_req  = 1'b1;
    @(negedge clk);
    run_req  = 1'b0;
  endtask

  // One run as seen from the core side; lat counts WAIT cycles up to and including ack
  task automatic do_run(input int id, input int lat, input bit drv, input bit poke,
                        input int expc, input int expto);
    int n;
    int cr;
    n  = 0;
    cr = 0;
    while (!start && n < 20) begin
      if (core_reset) cr++;
      @(negedge clk);
      n++;
    end
    check_vec("start_rise", int'(start), 1);
    check_vec("crst_cycles", cr, RST);
    check_vec("prog_sel", int'(prog_sel), id);
    check_vec("core_reset_in_strt", int'(core_reset), 0);
    n = 0;
    while (start && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_vec("start_len", n, STRC);
    if (poke) begin
      num_runs = 4'd5;
      run_req  = 1'b1;
      @(negedge clk);
      run_req  = 1'b0;
      check_vec("busy_after_poke", int'(busy), 1);
      check_vec("prog_sel_after_poke", int'(prog_sel), id);
    end
    if (drv) begin
      repeat (lat - 1 - (poke ? 1 : 0)) @(negedge clk);
      ack = 1'b1;
    end
    n = 0;
    while (!run_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_vec("run_valid", int'(run_valid), 1);
    check_vec("run_id", int'(run_id), id);
    check_vec("run_cycles", int'(run_cycles), expc);
    check_vec("timeout", int'(timeout), expto);
    check_vec("core_reset_in_rec", int'(core_reset), 1);
    if (drv) ack = 1'b0;
    @(negedge clk);
    check_vec("strobe_one_cycle", int'(run_valid), 0);
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    run_req  = 1'b0;
    num_runs = 4'd0;
    ack      = 1'b0;
    repeat (2) @(negedge clk);
    check_vec("rst_core_reset", int'(core_reset), 1);
    check_vec("rst_start", int'(start), 0);
    check_vec("rst_busy", int'(busy), 0);
    check_vec("rst_done", int'(done), 0);
    check_vec("rst_timeout", int'(timeout), 0);
    check_vec("rst_run_valid", int'(run_valid), 0);
    check_vec("rst_run_cycles", int'(run_cycles), 0);
    check_vec("rst_run_id", int'(run_id), 0);
    check_vec("rst_prog_sel", int'(prog_sel), 0);
    reset = 1'b0;
    @(negedge clk);
    check_vec("idle_busy", int'(busy), 0);

    // single run
    pulse_req(4'd0);
    check_vec("busy_after_req", int'(busy), 1);
    do_run(0, 7, 1'b1, 1'b0, 7, 0);
    check_vec("single_done", int'(done), 1);
    check_vec("single_busy", int'(busy), 0);

    // three-run batch from DONE
    pulse_req(4'd2);
    check_vec("done_cleared", int'(done), 0);
    do_run(0, 5, 1'b1, 1'b0, 5, 0);
    do_run(1, 9, 1'b1, 1'b0, 9, 0);
    do_run(2, 4, 1'b1, 1'b0, 4, 0);
    check_vec("batch_done", int'(done), 1);
    check_vec("batch_busy", int'(busy), 0);

    // timeout on both runs, batch still completes
    pulse_req(4'd1);
    do_run(0, 0, 1'b0, 1'b0, TO, 1);
    do_run(1, 0, 1'b0, 1'b0, TO, 1);
    check_vec("to_done", int'(done), 1);
    check_vec("to_latched", int'(timeout), 1);

    // ack stuck high through CRST/STRT; also checks timeout clears on accept
    ack = 1'b1;
    pulse_req(4'd0);
    check_vec("timeout_cleared", int'(timeout), 0);
    do_run(0, 1, 1'b0, 1'b0, 1, 0);
    check_vec("stuck_done", int'(done), 1);
    ack = 1'b0;
    @(negedge clk);

    // run_req during WAIT with num_runs=5 must be dropped
    pulse_req(4'd0);
    do_run(0, 6, 1'b1, 1'b1, 6, 0);
    check_vec("poke_done", int'(done), 1);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (start || busy) n++;
    end
    check_vec("poke_no_extra_run", n, 0);

    // reset mid-WAIT of the second run
    pulse_req(4'd3);
    do_run(0, 4, 1'b1, 1'b0, 4, 0);
    n = 0;
    while (!start && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (start && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_vec("pre_reset_prog_sel", int'(prog_sel), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_vec("mid_rst_core_reset", int'(core_reset), 1);
    check_vec("mid_rst_start", int'(start), 0);
    check_vec("mid_rst_busy", int'(busy), 0);
    check_vec("mid_rst_prog_sel", int'(prog_sel), 0);
    check_vec("mid_rst_done", int'(done), 0);
    @(negedge clk);
    pulse_req(4'd0);
    do_run(0, 3, 1'b1, 1'b0, 3, 0);
    check_vec("post_rst_done", int'(done), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
